// File: rtl/test_pattern_sequencer.sv
// test_pattern_sequencer
//   Frame-synchronous controller for the 4-bit pattern select of the VGA test
//   pattern generator. Manual next/prev requests and auto-cycling with a
//   programmable dwell are applied only at start-of-frame, with an optional
//   run of blank frames (pattern 0) between patterns.
//
// Ports:
//   i_clk          pixel clock
//   i_rst_n        asynchronous active-low reset
//   i_hpos/i_vpos  current raster position from the sync/counter block
//   i_next/i_prev  single-cycle requests to step the pattern forward/back
//   i_auto         level, enables auto-advance
//   i_dwell        frames per pattern in auto mode (0 behaves as 1)
//   o_pattern      registered pattern select (0 = blank, 1..NUM_PATTERNS)
//   o_frame_start  one-cycle pulse per frame, one cycle after hpos=vpos=0
//   o_busy         high while a change is pending or blanking
module test_pattern_sequencer #(
  parameter int NUM_PATTERNS  = 6,
  parameter int START_PATTERN = 1,
  parameter int BLANK_FRAMES  = 1,
  parameter int DWELL_W       = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [9:0]         i_hpos,
  input  logic [9:0]         i_vpos,
  input  logic               i_next,
  input  logic               i_prev,
  input  logic               i_auto,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [3:0]         o_pattern,
  output logic               o_frame_start,
  output logic               o_busy
);

  localparam logic [3:0]  NUM_P     = 4'(NUM_PATTERNS);
  localparam logic [3:0]  START_P   = 4'(START_PATTERN);
  localparam logic [15:0] BLANK_LIM = 16'(BLANK_FRAMES);

  typedef enum logic [1:0] {HOLD, PENDING, BLANK} state_t;

  state_t             state_q, state_d;
  logic [3:0]         pattern_q, pattern_d;
  logic [3:0]         target_q, target_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [15:0]        blank_cnt_q, blank_cnt_d;
  logic               busy_q, busy_d;
  logic               frame_start_q;
  logic               cond_q;

  logic               cond;
  logic               sof;
  logic               req;
  logic [DWELL_W:0]   dwell_eff;
  logic [DWELL_W:0]   dwell_next;
  logic               dwell_hit;
  logic               launch;
  logic [3:0]         launch_tgt;

  function automatic logic [3:0] next_pat(input logic [3:0] p);
    return (p >= NUM_P) ? 4'd1 : p + 4'd1;
  endfunction

  function automatic logic [3:0] prev_pat(input logic [3:0] p);
    return (p <= 4'd1) ? NUM_P : p - 4'd1;
  endfunction

  // A held hpos=vpos=0 must produce a single frame pulse, so detect the rising edge.
  assign cond = (i_hpos == 10'd0) && (i_vpos == 10'd0);
  assign sof  = cond && !cond_q;

  // Simultaneous next and prev cancel each other.
  assign req = i_next ^ i_prev;

  // Dwell of zero behaves as one; a dwell lowered below the count fires at once.
  assign dwell_eff  = (i_dwell == '0) ? {{DWELL_W{1'b0}}, 1'b1} : {1'b0, i_dwell};
  assign dwell_next = {1'b0, dwell_cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
  assign dwell_hit  = dwell_next >= dwell_eff;

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    target_d    = target_q;
    dwell_cnt_d = dwell_cnt_q;
    blank_cnt_d = blank_cnt_q;
    launch      = 1'b0;
    launch_tgt  = target_q;

    case (state_q)
      HOLD: begin
        // A request coinciding with sof is only latched; it waits for the next sof.
        if (req) begin
          target_d    = i_next ? next_pat(pattern_q) : prev_pat(pattern_q);
          state_d     = PENDING;
          dwell_cnt_d = '0;
        end else if (i_auto) begin
          if (sof) begin
            if (dwell_hit) begin
              launch      = 1'b1;
              launch_tgt  = next_pat(pattern_q);
              dwell_cnt_d = '0;
            end else begin
              dwell_cnt_d = dwell_next[DWELL_W-1:0];
            end
          end
        end else begin
          dwell_cnt_d = '0;
        end
      end
      PENDING: begin
        if (sof) begin
          launch     = 1'b1;
          launch_tgt = target_q;
        end
      end
      BLANK: begin
        if (sof) begin
          if (blank_cnt_q == BLANK_LIM) begin
            pattern_d = target_q;
            state_d   = HOLD;
          end else begin
            blank_cnt_d = blank_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = HOLD;
    endcase

    // Common change path for manual and auto advances.
    if (launch) begin
      target_d = launch_tgt;
      if (BLANK_FRAMES == 0) begin
        pattern_d = launch_tgt;
        state_d   = HOLD;
      end else begin
        pattern_d   = 4'd0;
        blank_cnt_d = 16'd1;
        state_d     = BLANK;
      end
    end

    busy_d = (state_d != HOLD);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= HOLD;
      pattern_q     <= START_P;
      target_q      <= START_P;
      dwell_cnt_q   <= '0;
      blank_cnt_q   <= '0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      cond_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      target_q      <= target_d;
      dwell_cnt_q   <= dwell_cnt_d;
      blank_cnt_q   <= blank_cnt_d;
      busy_q        <= busy_d;
      frame_start_q <= sof;
      cond_q        <= cond;
    end
  end

  assign o_pattern     = pattern_q;
  assign o_frame_start = frame_start_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Bench for test_pattern_sequencer: one instance with one blank frame between
// patterns and one switching directly. A 8x4 raster keeps frames 32 cycles long.
module tb_test_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       nxt, prv, aut;
  logic [7:0] dwell;
  logic [3:0] pat1, pat0;
  logic       fs1, fs0, busy1, busy0;

  int total = 0;
  int bad   = 0;
  int pos;
  bit freeze;
  bit c_prev;
  bit exp_fs;
  int pulses;

  always #5 clk = ~clk;

  test_pattern_sequencer #(.BLANK_FRAMES(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos),
    .i_next(nxt), .i_prev(prv), .i_auto(aut), .i_dwell(dwell),
    .o_pattern(pat1), .o_frame_start(fs1), .o_busy(busy1)
  );

  test_pattern_sequencer #(.BLANK_FRAMES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos),
    .i_next(nxt), .i_prev(prv), .i_auto(aut), .i_dwell(dwell),
    .o_pattern(pat0), .o_frame_start(fs0), .o_busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive_pos();
    hpos = 10'(pos % 8);
    vpos = 10'(pos / 8);
  endtask

  // One clock: sample 1 time unit after the edge, check the frame pulse model.
  task automatic cyc();
    bit c;
    c = (hpos == 10'd0) && (vpos == 10'd0);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_fs = 1'b0;
      c_prev = 1'b0;
    end else begin
      exp_fs = c && !c_prev;
      c_prev = c;
    end
    chk("fs_blank1", fs1, exp_fs);
    chk("fs_blank0", fs0, exp_fs);
    if (fs1) pulses++;
    if (!freeze) begin
      pos = (pos + 1) % 32;
      drive_pos();
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Leaves hpos=vpos=0 on the inputs, before the edge that sees it.
  task automatic to_pre_sof();
    int g;
    g = 0;
    while (pos != 0) begin
      cyc();
      g++;
      if (g > 40) begin
        $display("FAIL sof_wait observed=timeout expected=sof");
        $fatal(1, "raster stalled");
      end
    end
  endtask

  // Ends just after the edge on which a frame change is applied.
  task automatic to_sof();
    to_pre_sof();
    cyc();
  endtask

  task automatic pulse_next();
    nxt = 1'b1; cyc(); nxt = 1'b0;
  endtask

  task automatic pulse_prev();
    prv = 1'b1; cyc(); prv = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; nxt = 1'b0; prv = 1'b0; aut = 1'b0; dwell = 8'd3;
    pos = 5; drive_pos(); freeze = 1'b0; c_prev = 1'b0; pulses = 0;

    // Reset state
    run(3);
    chk("rst_pat1", pat1, 1);
    chk("rst_pat0", pat0, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy0", busy0, 0);
    rst_n = 1'b1;

    // Three idle frames: pattern stays 1, one pulse per frame
    pulses = 0;
    for (int i = 0; i < 96; i++) begin
      cyc();
      chk("idle_pat", pat1, 1);
    end
    chk("idle_pulses", pulses, 3);

    // hpos=vpos=0 held for several cycles gives one pulse
    to_pre_sof();
    freeze = 1'b1; pulses = 0;
    run(3);
    freeze = 1'b0;
    chk("held_pulses", pulses, 1);

    // Manual next with blanking; a second request while pending is ignored
    run(10);
    pulse_next();
    chk("next_busy1", busy1, 1);
    chk("next_pat1_hold", pat1, 1);
    chk("next_busy0", busy0, 1);
    run(3);
    pulse_next();
    chk("pend_busy1", busy1, 1);
    to_sof();
    chk("blank_pat1", pat1, 0);
    chk("blank_busy1", busy1, 1);
    chk("direct_pat0", pat0, 2);
    chk("direct_busy0", busy0, 0);
    run(10);
    chk("blank_mid_pat1", pat1, 0);
    pulse_next();  // ignored by the blanking instance
    chk("blank_req_busy1", busy1, 1);
    chk("hold_req_busy0", busy0, 1);
    chk("hold_req_pat0", pat0, 2);
    to_sof();
    chk("after_blank_pat1", pat1, 2);
    chk("after_blank_busy1", busy1, 0);
    chk("second_pat0", pat0, 3);
    chk("second_busy0", busy0, 0);

    // Request on the sof cycle waits for the following sof
    to_pre_sof();
    pulse_next();
    chk("sofreq_fs1", fs1, 1);
    chk("sofreq_pat1", pat1, 2);
    chk("sofreq_busy1", busy1, 1);
    chk("sofreq_pat0", pat0, 3);
    chk("sofreq_busy0", busy0, 1);
    to_sof();
    chk("sofreq_blank_pat1", pat1, 0);
    chk("sofreq_apply_pat0", pat0, 4);
    to_sof();
    chk("sofreq_apply_pat1", pat1, 3);
    chk("sofreq_done_busy1", busy1, 0);

    // Wrap: prev from 1 gives 6, next from 6 gives 1
    do_reset();
    run(5);
    chk("wrap_start_pat1", pat1, 1);
    pulse_prev();
    to_sof();
    chk("wrap_prev_pat0", pat0, 6);
    chk("wrap_prev_blank1", pat1, 0);
    to_sof();
    chk("wrap_prev_pat1", pat1, 6);
    pulse_next();
    to_sof();
    chk("wrap_next_pat0", pat0, 1);
    chk("wrap_next_blank1", pat1, 0);
    to_sof();
    chk("wrap_next_pat1", pat1, 1);
    chk("wrap_next_busy1", busy1, 0);

    // next and prev together: no change
    run(5);
    nxt = 1'b1; prv = 1'b1;
    cyc();
    nxt = 1'b0; prv = 1'b0;
    chk("both_busy1", busy1, 0);
    chk("both_busy0", busy0, 0);
    to_sof();
    chk("both_pat1", pat1, 1);
    chk("both_pat0", pat0, 1);

    // Auto mode on the direct-switch instance
    do_reset();
    run(5);
    aut = 1'b1; dwell = 8'd3;
    to_sof(); chk("auto3_a", pat0, 1);
    to_sof(); chk("auto3_b", pat0, 1);
    to_sof(); chk("auto3_c", pat0, 2);
    chk("auto3_blank1", pat1, 0);
    to_sof();
    to_sof(); chk("auto3_d", pat0, 2);
    to_sof(); chk("auto3_e", pat0, 3);
    dwell = 8'd0;
    run(3);
    to_sof(); chk("auto0_a", pat0, 4);
    to_sof(); chk("auto0_b", pat0, 5);
    // Dwell lowered below the accumulated count advances at the next sof
    dwell = 8'd5;
    to_sof(); to_sof(); to_sof();
    chk("lower_hold", pat0, 5);
    dwell = 8'd2;
    to_sof(); chk("lower_adv", pat0, 6);
    aut = 1'b0; dwell = 8'd3;

    // Reset asserted during blanking acts without a clock edge
    do_reset();
    run(3);
    pulse_next();
    to_sof();
    chk("pre_rst_pat1", pat1, 0);
    chk("pre_rst_busy1", busy1, 1);
    run(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pat1", pat1, 1);
    chk("async_busy1", busy1, 0);
    chk("async_fs1", fs1, 0);
    chk("async_pat0", pat0, 1);
    chk("async_busy0", busy0, 0);
    run(2);
    rst_n = 1'b1;
    to_sof();
    chk("post_rst_pat1_a", pat1, 1);
    chk("post_rst_busy1_a", busy1, 0);
    to_sof();
    chk("post_rst_pat1_b", pat1, 1);
    chk("post_rst_busy1_b", busy1, 0);
    chk("post_rst_pat0", pat0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_pattern_sequencer.md
Name: test_pattern_sequencer

Overview:
Frame-synchronous controller that drives the 4-bit pattern select of the VGA test pattern generator. Accepts manual next/prev requests and an auto-cycle mode with programmable dwell. Applies every pattern change only at start-of-frame and inserts configurable blank frames between patterns. Sits between the button/debounce logic and the pattern generator, on the pixel clock.

Parameters:
NUM_PATTERNS, 6, patterns 1..NUM_PATTERNS are cycled; legal range 1..15
START_PATTERN, 1, pattern selected out of reset; must be within 1..NUM_PATTERNS
BLANK_FRAMES, 1, full frames of pattern 0 shown between patterns; 0 means switch directly
DWELL_W, 8, width of the dwell input

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_hpos  in  10  current horizontal position from the sync/counter block
i_vpos  in  10  current vertical position
i_next  in  1  single-cycle pulse: advance one pattern
i_prev  in  1  single-cycle pulse: go back one pattern
i_auto  in  1  level: auto-advance enable
i_dwell  in  DWELL_W  frames per pattern in auto mode; 0 treated as 1
o_pattern  out  4  pattern select to generator
o_frame_start  out  1  one-cycle pulse per frame
o_busy  out  1  high while a change is pending or blanking

Behaviour:
- One clock; reset is asynchronous and active-low (i_clk, i_rst_n). All outputs registered.
- Reset values: o_pattern=START_PATTERN, o_frame_start=0, o_busy=0, state HOLD, dwell count 0, blank count 0, no pending request.
- SOF detect: cond = (i_hpos==0 && i_vpos==0); sof = cond && !cond_d (cond_d registered, reset 0). o_frame_start <= sof, so the pulse is 1 cycle after cond first seen. A held cond yields one pulse only.
- States: HOLD, PENDING, BLANK.
- HOLD: i_next XOR i_prev latches target = next/prev of o_pattern and goes to PENDING. i_next && i_prev together is ignored. A request in the same cycle as sof is latched; that sof is not used for it.
- HOLD, auto: when i_auto=1, each sof increments dwell count. When count+1 >= max(i_dwell,1), that sof performs the change to next pattern, with no PENDING stop. Count then clears. When i_auto=0, count is held at 0. A manual request also clears count. If i_dwell is lowered below the current count, the advance happens at the next sof.
- PENDING: o_busy=1. Further i_next/i_prev are ignored. The first sof performs the change.
- Change at sof, BLANK_FRAMES=0: o_pattern <= target on that edge, state HOLD.
- Change at sof, BLANK_FRAMES>0: o_pattern <= 0, blank count <= 1, state BLANK.
- BLANK: o_busy=1 and requests are ignored. On each sof, if blank count == BLANK_FRAMES then o_pattern <= target and state HOLD; otherwise blank count++. Pattern 0 is therefore visible for exactly BLANK_FRAMES frames.
- Wrap: next from NUM_PATTERNS gives 1; prev from 1 gives NUM_PATTERNS. o_pattern is never outside 0..NUM_PATTERNS.
- o_busy is registered and high in PENDING and BLANK, low in HOLD.
- i_rst_n asserted mid-operation (any state) immediately restores the reset values. A pending request is discarded.
- Latency: o_pattern changes on the same edge o_frame_start rises. The generator adds its own register stage.

Test Plan:
- Reset, no stimulus, 3 frames -> o_pattern=1 throughout; exactly one o_frame_start per frame, 1 cycle after hpos=vpos=0.
- BLANK_FRAMES=1, pulse i_next mid-frame with o_pattern=1 -> o_busy=1. At next sof o_pattern=0 for one full frame, then 2 at the following sof; o_busy falls with it.
- o_pattern=6, pulse i_next -> ends at 1. o_pattern=1, pulse i_prev -> ends at 6. Pulse i_next and i_prev in the same cycle -> no change, o_busy stays 0.
- Auto: i_auto=1, i_dwell=3, BLANK_FRAMES=0 -> o_pattern advances 1→2→3 every 3rd sof. i_dwell=0 -> advances every sof.
- Second i_next during PENDING/BLANK -> ignored, only one advance. i_next on the sof cycle -> applied at the following sof, not this one.
- Assert i_rst_n=0 during BLANK -> o_pattern=START_PATTERN and o_busy=0 immediately, without waiting for a clock. After release, no residual change occurs.
